// File: rtl/nibbler_button_port.sv
// Purpose: synchronise and debounce four pushbuttons, hold the latest settled nibble for a uP read.
// Latency: a held level change sampled into sync1 at edge N reaches stable/hold at edge N+1+DEB_CYCLES.
// Backpressure: none; an unread nibble is overwritten by a newer capture and the sticky overrun flag is raised.
module nibbler_button_port #(
    parameter int DEB_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] pushbuttons,
    input  logic       rd_en,
    output logic [3:0] data_bus,
    output logic       data_valid,
    output logic       overrun,
    output logic [3:0] press_pulse
);

    localparam logic [3:0] CNT_MAX = 4'(DEB_CYCLES - 1);

    logic [3:0] sync1;
    logic [3:0] sync2;
    logic [3:0] stable;
    logic [3:0] stable_nxt;
    logic [3:0] hold;
    logic [3:0] cnt     [4];
    logic [3:0] cnt_nxt [4];
    logic       capture;

    // A bit is accepted only after differing from stable for DEB_CYCLES consecutive cycles.
    always_comb begin
        stable_nxt = stable;
        for (int i = 0; i < 4; i++) begin
            cnt_nxt[i] = 4'd0;
            if (sync2[i] != stable[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    stable_nxt[i] = sync2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + 4'd1;
                end
            end
        end
    end

    assign capture  = (stable_nxt != stable);
    assign data_bus = hold;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1       <= 4'd0;
            sync2       <= 4'd0;
            stable      <= 4'd0;
            hold        <= 4'd0;
            data_valid  <= 1'b0;
            overrun     <= 1'b0;
            press_pulse <= 4'd0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= 4'd0;
            end
        end else begin
            sync1       <= pushbuttons;
            sync2       <= sync1;
            stable      <= stable_nxt;
            press_pulse <= stable_nxt & ~stable;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
            // Capture beats a same-edge read; that read still consumes the old value.
            if (capture) begin
                hold       <= stable_nxt;
                data_valid <= 1'b1;
                if (data_valid) begin
                    overrun <= !rd_en;
                end
            end else if (rd_en && data_valid) begin
                data_valid <= 1'b0;
                overrun    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_nibbler_button_port.sv
// Directed bench for nibbler_button_port with DEB_CYCLES=4 and a 10-unit clock.
module tb_nibbler_button_port;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] pushbuttons;
    logic       rd_en;
    logic [3:0] data_bus;
    logic       data_valid;
    logic       overrun;
    logic [3:0] press_pulse;

    int compared   = 0;
    int mismatched = 0;

    nibbler_button_port #(.DEB_CYCLES(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .pushbuttons (pushbuttons),
        .rd_en       (rd_en),
        .data_bus    (data_bus),
        .data_valid  (data_valid),
        .overrun     (overrun),
        .press_pulse (press_pulse)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] acc;

        reset       = 1'b0;
        pushbuttons = 4'b0000;
        rd_en       = 1'b0;
        #1;
        chk("reset_bus",   data_bus,           4'b0000);
        chk("reset_flags", {2'b00, data_valid, overrun}, 4'b0000);
        chk("reset_press", press_pulse,        4'b0000);
        tick(2);
        reset = 1'b1;

        // First press: sync1 samples at edge N, capture at N+5
        pushbuttons = 4'b1100;
        tick(5);
        chk("press_dv_early", {3'b000, data_valid}, 4'b0000);
        tick(1);
        chk("press_bus",   data_bus,    4'b1100);
        chk("press_dv",    {3'b000, data_valid}, 4'b0001);
        chk("press_pulse", press_pulse, 4'b1100);
        chk("press_ovr",   {3'b000, overrun}, 4'b0000);
        tick(1);
        chk("press_pulse_end", press_pulse, 4'b0000);

        // Two-cycle glitch is rejected
        pushbuttons = 4'b0011;
        tick(2);
        pushbuttons = 4'b1100;
        acc = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            acc = acc | press_pulse;
        end
        chk("glitch_pulse", acc,      4'b0000);
        chk("glitch_bus",   data_bus, 4'b1100);
        chk("glitch_flags", {2'b00, data_valid, overrun}, 4'b0010);

        // Overwrite of unread 1100
        pushbuttons = 4'b0011;
        tick(5);
        chk("ovr_bus_early", data_bus, 4'b1100);
        tick(1);
        chk("ovr_bus",   data_bus,    4'b0011);
        chk("ovr_flags", {2'b00, data_valid, overrun}, 4'b0011);
        chk("ovr_pulse", press_pulse, 4'b0011);
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        chk("ovr_read_flags", {2'b00, data_valid, overrun}, 4'b0000);

        // Read handshake
        pushbuttons = 4'b1100;
        tick(6);
        chk("rd_cap_bus",   data_bus,    4'b1100);
        chk("rd_cap_flags", {2'b00, data_valid, overrun}, 4'b0010);
        chk("rd_cap_pulse", press_pulse, 4'b1100);
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        chk("rd1_flags", {2'b00, data_valid, overrun}, 4'b0000);
        chk("rd1_bus",   data_bus, 4'b1100);
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        chk("rd2_flags", {2'b00, data_valid, overrun}, 4'b0000);
        chk("rd2_bus",   data_bus, 4'b1100);

        // Build up an overrun, then capture coincident with a read
        pushbuttons = 4'b0000;
        tick(7);
        chk("rel_bus",   data_bus, 4'b0000);
        chk("rel_flags", {2'b00, data_valid, overrun}, 4'b0010);
        pushbuttons = 4'b1000;
        tick(7);
        chk("pre_bus",   data_bus, 4'b1000);
        chk("pre_flags", {2'b00, data_valid, overrun}, 4'b0011);
        pushbuttons = 4'b0010;
        tick(5);
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        chk("coin_bus",   data_bus,    4'b0010);
        chk("coin_flags", {2'b00, data_valid, overrun}, 4'b0010);
        chk("coin_pulse", press_pulse, 4'b0010);

        // Reset mid-debounce, then re-debounce after release
        pushbuttons = 4'b0110;
        tick(3);
        #1;
        reset = 1'b0;
        #1;
        chk("mid_rst_bus",   data_bus,    4'b0000);
        chk("mid_rst_flags", {2'b00, data_valid, overrun}, 4'b0000);
        chk("mid_rst_pulse", press_pulse, 4'b0000);
        tick(2);
        reset = 1'b1;
        tick(5);
        chk("post_rst_early", {data_valid, press_pulse[2:0]}, 4'b0000);
        tick(1);
        chk("post_rst_bus",   data_bus,    4'b0110);
        chk("post_rst_flags", {2'b00, data_valid, overrun}, 4'b0010);
        chk("post_rst_pulse", press_pulse, 4'b0110);
        tick(1);
        chk("post_rst_pulse_end", press_pulse, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
